// File: rtl/bus_wait_gen.sv
// Per-access wait-state generator for the 65C02 bus: stalls RDY by a region-specific count and
// owns the wait config register. Define WAIT_STATS_EN to add the rdy-low cycle statistics counter.
module bus_wait_gen #(
   parameter logic [15:0] CFG_ADDR         = 16'h7FF0,
   parameter logic [3:0]  ROM_WAIT_DEFAULT = 4'd2,
   parameter logic [3:0]  IO_WAIT_DEFAULT  = 4'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        addr_valid,
   input  logic [15:0] addr,
   input  logic        we,
   input  logic [7:0]  data_in,
   input  logic        ram_cs,
   input  logic        rom_cs,
   input  logic        io_cs,
   output logic        rdy,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        err
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [7:0]  cfg;
   logic [3:0]  wait_n;
   logic        accept;
   logic        cfg_hit;
   logic        rd_hit;
   logic [7:0]  rd_data;

`ifdef WAIT_STATS_EN
   localparam logic [15:0] STAT_LO_ADDR = CFG_ADDR + 16'd1;
   localparam logic [15:0] STAT_HI_ADDR = CFG_ADDR + 16'd2;
   logic [15:0] stat_cnt;
`endif

   // Accesses arriving while a stall is in progress are protocol errors and are not serviced.
   assign accept  = addr_valid && (state == ST_IDLE);
   assign cfg_hit = io_cs && (addr == CFG_ADDR);

   always_comb begin
      wait_n = 4'd0;
      if (io_cs)
         wait_n = cfg[3:0];
      else if (rom_cs)
         wait_n = cfg[7:4];
      else if (ram_cs)
         wait_n = 4'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The addr_valid cycle itself supplies the first low cycle, so WAIT covers the remaining N-1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (addr_valid && (wait_n > 4'd1)) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = wait_n - 4'd2;
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0)
               state_nxt = ST_IDLE;
            else
               cnt_nxt = cnt - 4'd1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rdy = 1'b1;
      case (state)
         ST_IDLE: if (addr_valid && (wait_n != 4'd0)) rdy = 1'b0;
         ST_WAIT: rdy = 1'b0;
         default: rdy = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (addr_valid && (state == ST_WAIT))
         err <= 1'b1;
   end

   // The stall for this access was already computed from the old cfg, so the write lands cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cfg <= {ROM_WAIT_DEFAULT, IO_WAIT_DEFAULT};
      else if (accept && cfg_hit && we)
         cfg <= data_in;
   end

   always_comb begin
      rd_hit  = 1'b0;
      rd_data = 8'h00;
      if (io_cs && !we) begin
         if (addr == CFG_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = cfg;
         end
`ifdef WAIT_STATS_EN
         else if (addr == STAT_LO_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = stat_cnt[7:0];
         end else if (addr == STAT_HI_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = stat_cnt[15:8];
         end
`endif
      end
   end

   // Read data is captured per access and held until the next serviced access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_oe  <= 1'b0;
         data_out <= 8'h00;
      end else if (accept) begin
         data_oe  <= rd_hit;
         data_out <= rd_data;
      end
   end

`ifdef WAIT_STATS_EN
   // A clearing write wins over the increment from that same access's own stall cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stat_cnt <= 16'h0000;
      else if (accept && io_cs && we && (addr == STAT_LO_ADDR))
         stat_cnt <= 16'h0000;
      else if (!rdy && (stat_cnt != 16'hFFFF))
         stat_cnt <= stat_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed bench for bus_wait_gen: stall lengths per region, config register access, error and
// reset behaviour, and the statistics counter when WAIT_STATS_EN is defined.
module tb_bus_wait_gen;

   localparam logic [15:0] CFG  = 16'h7FF0;
   localparam logic [15:0] CFG1 = 16'h7FF1;
   localparam logic [15:0] CFG2 = 16'h7FF2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        addr_valid = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        ram_cs = 1'b0;
   logic        rom_cs = 1'b0;
   logic        io_cs = 1'b0;
   logic        rdy;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        err;

   int vectors = 0;
   int miscompares = 0;
   int lows = 0;

   bus_wait_gen dut (
      .clk(clk), .rst_n(rst_n), .addr_valid(addr_valid), .addr(addr), .we(we),
      .data_in(data_in), .ram_cs(ram_cs), .rom_cs(rom_cs), .io_cs(io_cs),
      .rdy(rdy), .data_out(data_out), .data_oe(data_oe), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Present an access in the current cycle and count its first low cycle.
   task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic ra, input logic ro, input logic io);
      addr = a; we = w; data_in = d;
      ram_cs = ra; rom_cs = ro; io_cs = io;
      addr_valid = 1'b1;
      #1;
      lows = (rdy === 1'b0) ? 1 : 0;
   endtask

   // Idle the bus and count further low cycles until rdy returns high.
   task automatic run_stall();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         addr_valid = 1'b0; we = 1'b0;
         ram_cs = 1'b0; rom_cs = 1'b0; io_cs = 1'b0;
         #1;
         if (rdy === 1'b1) return;
         lows++;
      end
      chk("stall_bound", rdy, 1'b1);
   endtask

   task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                         input logic ra, input logic ro, input logic io);
      @(negedge clk);
      drive(a, w, d, ra, ro, io);
      run_stall();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy", rdy, 1'b1);
      chk("rst_oe", data_oe, 1'b0);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_err", err, 1'b0);
      rst_n = 1'b1;

      access(16'h1234, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("ram_stall", lows, 0);
      chk("ram_err", err, 1'b0);

      access(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("rom_stall_dflt", lows, 2);
      drive(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      run_stall();
      chk("b2b_stall", lows, 2);
      chk("b2b_err", err, 1'b0);

      access(CFG, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
      chk("cfgwr_stall", lows, 1);
      access(16'h7F00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("io_stall_new", lows, 0);
      chk("io_other_oe", data_oe, 1'b0);
      access(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("rom_stall_new", lows, 3);
      access(CFG, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("cfgrd_stall", lows, 0);
      chk("cfgrd_data", data_out, 8'h30);
      chk("cfgrd_oe", data_oe, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      chk("cfgrd_hold_oe", data_oe, 1'b1);
      chk("cfgrd_hold_data", data_out, 8'h30);
      access(16'h1234, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("oe_drop", data_oe, 1'b0);

      access(CFG, 1'b1, 8'h51, 1'b0, 1'b0, 1'b1);
      chk("cfgwr_io0", lows, 0);
      access(16'h7F00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("io_over_rom", lows, 1);
      access(16'h0200, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("no_cs_stall", lows, 0);

      access(CFG, 1'b1, 8'hF1, 1'b0, 1'b0, 1'b1);
      chk("cfgwr_f1", lows, 1);
      @(negedge clk);
      drive(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         addr_valid = (i == 2 || i == 6);
         rom_cs = addr_valid;
         #1;
         if (rdy === 1'b1) break;
         lows++;
      end
      addr_valid = 1'b0; rom_cs = 1'b0;
      chk("rom15_stall", lows, 15);
      chk("rom15_err", err, 1'b1);

      @(negedge clk);
      drive(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         addr_valid = 1'b0; rom_cs = 1'b0;
      end
      #2;
      chk("mid_stall_low", rdy, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rdy", rdy, 1'b1);
      chk("async_rst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      access(CFG, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_cfg_stall", lows, 1);
      chk("rst_cfg_data", data_out, 8'h21);
      chk("rst_cfg_oe", data_oe, 1'b1);

`ifdef WAIT_STATS_EN
      do_reset();
      repeat (3) begin
         access(16'hC000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("stat_rom_stall", lows, 2);
      end
      access(CFG1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("stat_lo", data_out, 8'h06);
      chk("stat_lo_oe", data_oe, 1'b1);
      access(CFG2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("stat_hi", data_out, 8'h00);
      access(CFG1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      access(CFG1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("stat_clr", data_out, 8'h00);
`else
      access(CFG1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("unmapped_oe", data_oe, 1'b0);
      access(CFG1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
      access(CFG, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("unmapped_wr", data_out, 8'h21);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
